ex_muldiv_unit: RTL and testbench
=================================

// Module: ex_muldiv_unit
// PURPOSE
//   Iterative multiply/divide unit for the EX stage: MULT, MULTU, DIV, DIVU into HI/LO.
//   Sits beside the EX ALU. Drives the EX stall request while an operation runs.
//   Presents HI/LO to the write-back path on a one-cycle done pulse.
// PARAMETERS
//   WIDTH   32   operand width; HI and LO are WIDTH bits each; iteration count = WIDTH
//   CNT_W   6    iteration counter width; must satisfy 2**CNT_W > WIDTH
// PORTS
//   clk         in   1       clock, rising edge
//   rst         in   1       reset, synchronous, active-high
//   start_i     in   1       start request, sampled only in IDLE
//   op_i        in   2       00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start_i
//   a_i         in   WIDTH   multiplicand / dividend (rs)
//   b_i         in   WIDTH   multiplier / divisor (rt)
//   cancel_i    in   1       flush: abort any operation, no result
//   busy_o      out  1       high in RUN and DONE
//   done_o      out  1       one-cycle pulse; hi_o/lo_o valid in the same cycle
//   hi_o        out  WIDTH   MUL: product[2W-1:W]; DIV: remainder
//   lo_o        out  WIDTH   MUL: product[W-1:0]; DIV: quotient
//   stallreq_o  out  1       comb: (IDLE & start_i & ~cancel_i) | RUN; low in DONE
// BEHAVIOUR
//   Reset: state=IDLE; busy_o, done_o, hi_o, lo_o and counter all 0. Applies mid-op too; work is discarded.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//   - IDLE, start_i & ~cancel_i: latch op and operand magnitudes (signed ops take |x|),
//     latch result-sign flags, counter=WIDTH, go to RUN. Divisor==0 goes straight to DONE instead.
//   - RUN: one radix-2 step per cycle. MUL: shift-add. DIV: restoring shift-subtract.
//     Counter decrements; at counter==1 the next state is DONE.
//   - DONE: apply sign fix-up, update hi_o/lo_o, done_o=1 for exactly this cycle, go to IDLE.
//   Latency: start accepted in cycle T -> done_o in cycle T+WIDTH+1; busy_o high T+1..T+WIDTH+1.
//   Signed MUL: 2W-bit two's-complement product.
//   Signed DIV: quotient truncates toward zero; remainder takes the dividend's sign.
//   Overflow case -2^(W-1) / -1 -> lo=2^(W-1) (wrapped), hi=0. No exception raised.
//   Divide by zero (DIV or DIVU): done in T+1, hi=a_i, lo=all ones.
//   start_i outside IDLE is ignored (no queueing); the EX stall guarantees it does not occur.
//   cancel_i in RUN/DONE: next state IDLE, done_o suppressed, hi_o/lo_o keep prior values.
//   cancel_i with start_i in IDLE: cancel wins, start dropped.
//   hi_o/lo_o hold their last values between operations; they change only in the DONE cycle.
// CONFIGURATION
//   MULDIV_FAST_MUL_EN defined: MULT/MULTU use a single-cycle array multiply.
//     IDLE -> DONE directly; done_o at T+1; divide latency is unchanged.
//   Not defined: multiplies iterate WIDTH cycles as described above; no wide multiplier is inferred.
// TESTING (WIDTH=32)
//   MULTU a=0xFFFFFFFF b=0xFFFFFFFF at T -> done_o at T+33 (T+1 fast), hi=0xFFFFFFFE lo=0x00000001
//   MULT a=0xFFFFFFFD(-3) b=5 -> hi=0xFFFFFFFF lo=0xFFFFFFF1; stallreq_o high T..T+32, low at T+33
//   DIV a=0xFFFFFFF9(-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU 7/2 -> lo=3 hi=1; DIV 0x80000000/-1 -> lo=0x80000000 hi=0
//   DIVU a=5 b=0 at T -> done_o at T+1, hi=5 lo=0xFFFFFFFF, busy_o low at T+2
//   DIVU started at T; start_i pulsed at T+3 -> ignored. cancel_i at T+10 -> IDLE at T+11, no done_o, hi/lo unchanged
//   rst asserted at T+5 mid-DIV -> cycle T+6: busy_o=0 done_o=0 hi_o=0 lo_o=0; a fresh op afterwards completes normally

Source files
------------

// File: rtl/ex_muldiv_if.sv
// Bus between the EX stage and the iterative multiply/divide unit.
//
// Handshake: the EX stage raises start_i with op_i/a_i/b_i for one cycle while
// the unit is idle (busy_o low); the request is taken on that rising edge unless
// cancel_i is also high. The unit answers with a single-cycle done_o pulse and
// hi_o/lo_o are valid in that same cycle. There is no back-pressure on done_o.
// cancel_i flushes any accepted operation without a result. state_o exposes the
// controller state for debug.
interface ex_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start_i;
   logic [1:0]       op_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             cancel_i;
   logic             busy_o;
   logic             done_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;
   logic             stallreq_o;
   logic [1:0]       state_o;

   modport master (
      output start_i, op_i, a_i, b_i, cancel_i,
      input  busy_o, done_o, hi_o, lo_o, stallreq_o, state_o
   );

   modport slave (
      input  start_i, op_i, a_i, b_i, cancel_i,
      output busy_o, done_o, hi_o, lo_o, stallreq_o, state_o
   );
endinterface

// File: rtl/ex_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage, results into HI/LO.
// Radix-2: one shift-add (multiply) or restoring shift-subtract (divide) step
// per cycle on operand magnitudes, sign fix-up applied in the DONE cycle.
// Optional build macro MULDIV_FAST_MUL_EN: multiplies complete in one cycle
// through an array multiplier; divides still iterate.
module ex_muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic       clk,
   input  logic       rst,
   ex_muldiv_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] acc_q;     // MUL: product high half; DIV: partial remainder
   logic [WIDTH-1:0] mq_q;      // MUL: multiplier / product low half; DIV: dividend / quotient
   logic [WIDTH-1:0] bop_q;     // MUL: multiplicand magnitude; DIV: divisor magnitude
   logic             div_q;
   logic             neg_lo_q;  // negate product (MUL) or quotient (DIV)
   logic             neg_hi_q;  // negate remainder (DIV only)
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;

   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic             accept;

   // Operand magnitudes; unsigned ops (op_i[0]=1) never negate.
   always_comb begin
      a_neg  = ~bus.op_i[0] & bus.a_i[WIDTH-1];
      b_neg  = ~bus.op_i[0] & bus.b_i[WIDTH-1];
      a_mag  = a_neg ? -bus.a_i : bus.a_i;
      b_mag  = b_neg ? -bus.b_i : bus.b_i;
      accept = (state_q == S_IDLE) & bus.start_i & ~bus.cancel_i;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] ext_a;
   logic [2*WIDTH-1:0] ext_b;
   logic [2*WIDTH-1:0] fast_prod;

   // Single-cycle product: extending both operands to 2W bits makes the low
   // 2W bits of the product correct for both signed and unsigned forms.
   always_comb begin
      ext_a     = {{WIDTH{bus.a_i[WIDTH-1] & ~bus.op_i[0]}}, bus.a_i};
      ext_b     = {{WIDTH{bus.b_i[WIDTH-1] & ~bus.op_i[0]}}, bus.b_i};
      fast_prod = ext_a * ext_b;
   end
`endif

   logic [WIDTH-1:0] mul_add;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_trial;
   logic [WIDTH-1:0] step_acc;
   logic [WIDTH-1:0] step_mq;

   // One radix-2 step. The partial remainder stays below the divisor, so bit W
   // of the trial difference is set exactly when the subtraction borrows.
   always_comb begin
      mul_add   = mq_q[0] ? bop_q : {WIDTH{1'b0}};
      mul_sum   = {1'b0, acc_q} + {1'b0, mul_add};
      div_shift = {acc_q, mq_q[WIDTH-1]};
      div_trial = div_shift - {1'b0, bop_q};
      if (div_q) begin
         if (!div_trial[WIDTH]) begin
            step_acc = div_trial[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], 1'b1};
         end else begin
            step_acc = div_shift[WIDTH-1:0];
            step_mq  = {mq_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         step_acc = mul_sum[WIDTH:1];
         step_mq  = {mul_sum[0], mq_q[WIDTH-1:1]};
      end
   end

   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   fix_hi;
   logic [WIDTH-1:0]   fix_lo;

   // Sign fix-up of the finished magnitude result, valid while in DONE.
   always_comb begin
      prod_fix = neg_lo_q ? -{acc_q, mq_q} : {acc_q, mq_q};
      if (div_q) begin
         fix_hi = neg_hi_q ? -acc_q : acc_q;
         fix_lo = neg_lo_q ? -mq_q : mq_q;
      end else begin
         fix_hi = prod_fix[2*WIDTH-1:WIDTH];
         fix_lo = prod_fix[WIDTH-1:0];
      end
   end

   // Controller and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         mq_q     <= '0;
         bop_q    <= '0;
         div_q    <= 1'b0;
         neg_lo_q <= 1'b0;
         neg_hi_q <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  div_q <= bus.op_i[1];
                  if (bus.op_i[1]) begin
                     if (bus.b_i == '0) begin
                        // Divide by zero: fixed result, no iteration.
                        acc_q    <= bus.a_i;
                        mq_q     <= '1;
                        neg_lo_q <= 1'b0;
                        neg_hi_q <= 1'b0;
                        state_q  <= S_DONE;
                     end else begin
                        acc_q    <= '0;
                        mq_q     <= a_mag;
                        bop_q    <= b_mag;
                        neg_lo_q <= a_neg ^ b_neg;
                        neg_hi_q <= a_neg;
                        cnt_q    <= CNT_W'(WIDTH);
                        state_q  <= S_RUN;
                     end
                  end else begin
`ifdef MULDIV_FAST_MUL_EN
                     acc_q    <= fast_prod[2*WIDTH-1:WIDTH];
                     mq_q     <= fast_prod[WIDTH-1:0];
                     neg_lo_q <= 1'b0;
                     neg_hi_q <= 1'b0;
                     state_q  <= S_DONE;
`else
                     acc_q    <= '0;
                     mq_q     <= b_mag;
                     bop_q    <= a_mag;
                     neg_lo_q <= a_neg ^ b_neg;
                     neg_hi_q <= 1'b0;
                     cnt_q    <= CNT_W'(WIDTH);
                     state_q  <= S_RUN;
`endif
                  end
               end
            end
            S_RUN: begin
               if (bus.cancel_i) begin
                  cnt_q   <= '0;
                  state_q <= S_IDLE;
               end else begin
                  acc_q <= step_acc;
                  mq_q  <= step_mq;
                  cnt_q <= cnt_q - CNT_W'(1);
                  if (cnt_q == CNT_W'(1)) begin
                     state_q <= S_DONE;
                  end
               end
            end
            S_DONE: begin
               if (!bus.cancel_i) begin
                  hi_q <= fix_hi;
                  lo_q <= fix_lo;
               end
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs: the fixed-up result is forwarded during the DONE cycle and held
   // in hi_q/lo_q afterwards, so a cancel in DONE leaves HI/LO untouched.
   always_comb begin
      bus.done_o     = (state_q == S_DONE) & ~bus.cancel_i;
      bus.busy_o     = (state_q != S_IDLE);
      bus.hi_o       = bus.done_o ? fix_hi : hi_q;
      bus.lo_o       = bus.done_o ? fix_lo : lo_q;
      bus.stallreq_o = accept | (state_q == S_RUN);
      bus.state_o    = state_q;
   end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit (WIDTH=32) against an arithmetic
// reference model of MULT/MULTU/DIV/DIVU.
module tb_ex_muldiv_unit;

   localparam int W = 32;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ex_muldiv_if #(.WIDTH(W)) mif ();

   ex_muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (mif)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   logic [W-1:0] last_hi = '0;
   logic [W-1:0] last_lo = '0;

   bit stall_tr[$];
   bit busy_tr[$];

   // Reference model computed with plain 64-bit arithmetic.
   function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] hi, output logic [W-1:0] lo);
      longint      sa, sb, sp, sq, sr;
      logic [63:0] up;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin
            sp = sa * sb;
            up = sp;
            hi = up[63:32];
            lo = up[31:0];
         end
         2'b01: begin
            up = {32'd0, a} * {32'd0, b};
            hi = up[63:32];
            lo = up[31:0];
         end
         default: begin
            if (b == '0) begin
               hi = a;
               lo = '1;
            end else if (op == 2'b11) begin
               hi = a % b;
               lo = a / b;
            end else begin
               sq = sa / sb;
               sr = sa % sb;
               up = sq;
               lo = up[31:0];
               up = sr;
               hi = up[31:0];
            end
         end
      endcase
   endfunction

   function automatic int exp_latency(input logic [1:0] op, input logic [W-1:0] b);
      if (op[1] && b == '0) return 1;
`ifdef MULDIV_FAST_MUL_EN
      if (!op[1]) return 1;
`endif
      return W + 1;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Issue one operation from IDLE and follow it to the cycle after done_o.
   task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output logic [W-1:0] hi, output logic [W-1:0] lo,
                         output logic [W-1:0] hi_after, output logic [W-1:0] lo_after,
                         output bit seen);
      stall_tr.delete();
      busy_tr.delete();
      mif.op_i    = op;
      mif.a_i     = a;
      mif.b_i     = b;
      mif.start_i = 1'b1;
      #1;
      stall_tr.push_back(mif.stallreq_o);
      busy_tr.push_back(mif.busy_o);
      lat  = 0;
      seen = 1'b0;
      hi   = '0;
      lo   = '0;
      while (!seen && lat < 100) begin
         @(posedge clk);
         #1;
         mif.start_i = 1'b0;
         #1;
         lat++;
         stall_tr.push_back(mif.stallreq_o);
         busy_tr.push_back(mif.busy_o);
         if (mif.done_o) begin
            seen = 1'b1;
            hi   = mif.hi_o;
            lo   = mif.lo_o;
         end
      end
      @(posedge clk);
      #2;
      stall_tr.push_back(mif.stallreq_o);
      busy_tr.push_back(mif.busy_o);
      hi_after = mif.hi_o;
      lo_after = mif.lo_o;
   endtask

   task automatic test_reset;
      rst          = 1'b1;
      mif.start_i  = 1'b0;
      mif.cancel_i = 1'b0;
      mif.op_i     = 2'b00;
      mif.a_i      = '0;
      mif.b_i      = '0;
      repeat (3) tick();
      rst = 1'b0;
      #1;
      n_cmp++; if (mif.busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b want=0", mif.busy_o); end
      n_cmp++; if (mif.done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b want=0", mif.done_o); end
      n_cmp++; if (mif.hi_o !== '0) begin n_err++; $display("FAIL reset_hi got=%h want=0", mif.hi_o); end
      n_cmp++; if (mif.lo_o !== '0) begin n_err++; $display("FAIL reset_lo got=%h want=0", mif.lo_o); end
      n_cmp++; if (mif.stallreq_o !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b want=0", mif.stallreq_o); end
      last_hi = '0;
      last_lo = '0;
   endtask

   task automatic test_vectors;
      logic [1:0]   ops[6] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b10, 2'b11};
      logic [W-1:0] as[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5};
      logic [W-1:0] bs[6]  = '{32'hFFFFFFFF, 32'd5, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
      logic [W-1:0] ehs[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd5};
      logic [W-1:0] els[6] = '{32'h00000001, 32'hFFFFFFF1, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'hFFFFFFFF};
      int lat, bad;
      logic [W-1:0] hi, lo, hi2, lo2;
      bit seen;
      for (int i = 0; i < 6; i++) begin
         run_op(ops[i], as[i], bs[i], lat, hi, lo, hi2, lo2, seen);
         n_cmp++; if (!seen || lat != exp_latency(ops[i], bs[i])) begin
            n_err++; $display("FAIL vec%0d_latency got=%0d seen=%b want=%0d", i, lat, seen, exp_latency(ops[i], bs[i]));
         end
         n_cmp++; if (hi !== ehs[i]) begin n_err++; $display("FAIL vec%0d_hi got=%h want=%h", i, hi, ehs[i]); end
         n_cmp++; if (lo !== els[i]) begin n_err++; $display("FAIL vec%0d_lo got=%h want=%h", i, lo, els[i]); end
         n_cmp++; if (hi2 !== ehs[i] || lo2 !== els[i]) begin
            n_err++; $display("FAIL vec%0d_hold got=%h_%h want=%h_%h", i, hi2, lo2, ehs[i], els[i]);
         end
         bad = 0;
         for (int k = 0; k < stall_tr.size(); k++) begin
            if (stall_tr[k] !== (k < lat)) bad++;
            if (busy_tr[k] !== (k >= 1 && k <= lat)) bad++;
         end
         n_cmp++; if (bad != 0) begin n_err++; $display("FAIL vec%0d_stall_busy got=%0d bad cycles want=0", i, bad); end
         last_hi = ehs[i];
         last_lo = els[i];
      end
   endtask

   task automatic test_random;
      logic [W-1:0] special[5] = '{32'd0, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
      logic [1:0]   op;
      logic [W-1:0] a, b, eh, el, hi, lo, hi2, lo2;
      int lat, bad;
      bit seen;
      for (int n = 0; n < 40; n++) begin
         op = 2'($urandom_range(0, 3));
         a  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
         b  = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 4)] : $urandom;
         if ($urandom_range(0, 2) == 0) b = W'($urandom_range(1, 9));
         model(op, a, b, eh, el);
         run_op(op, a, b, lat, hi, lo, hi2, lo2, seen);
         n_cmp++; if (!seen || lat != exp_latency(op, b)) begin
            n_err++; $display("FAIL rnd%0d_latency op=%0d got=%0d want=%0d", n, op, lat, exp_latency(op, b));
         end
         n_cmp++; if (hi !== eh || lo !== el) begin
            n_err++; $display("FAIL rnd%0d_result op=%0d a=%h b=%h got=%h_%h want=%h_%h", n, op, a, b, hi, lo, eh, el);
         end
         n_cmp++; if (hi2 !== eh || lo2 !== el) begin
            n_err++; $display("FAIL rnd%0d_hold got=%h_%h want=%h_%h", n, hi2, lo2, eh, el);
         end
         bad = 0;
         for (int k = 0; k < stall_tr.size(); k++) begin
            if (stall_tr[k] !== (k < lat)) bad++;
            if (busy_tr[k] !== (k >= 1 && k <= lat)) bad++;
         end
         n_cmp++; if (bad != 0) begin n_err++; $display("FAIL rnd%0d_stall_busy got=%0d bad cycles want=0", n, bad); end
         last_hi = eh;
         last_lo = el;
      end
   endtask

   task automatic test_cancel;
      int  done_seen, busy_seen;
      // DIVU at T, stray start at T+3, cancel at T+10.
      mif.op_i    = 2'b11;
      mif.a_i     = 32'd1000;
      mif.b_i     = 32'd7;
      mif.start_i = 1'b1;
      done_seen   = 0;
      tick();
      mif.start_i = 1'b0;
      for (int c = 1; c < 10; c++) begin
         if (c == 3) begin mif.start_i = 1'b1; mif.op_i = 2'b01; mif.a_i = 32'd3; mif.b_i = 32'd3; end
         #1;
         if (mif.done_o) done_seen++;
         tick();
         mif.start_i = 1'b0;
      end
      mif.cancel_i = 1'b1;
      #1;
      if (mif.done_o) done_seen++;
      tick();
      mif.cancel_i = 1'b0;
      #1;
      n_cmp++; if (mif.busy_o !== 1'b0) begin n_err++; $display("FAIL cancel_run_idle got=%b want=0", mif.busy_o); end
      busy_seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (mif.done_o) done_seen++;
         if (mif.busy_o) busy_seen++;
         tick();
      end
      n_cmp++; if (done_seen != 0) begin n_err++; $display("FAIL cancel_run_done got=%0d pulses want=0", done_seen); end
      n_cmp++; if (busy_seen != 0) begin n_err++; $display("FAIL cancel_no_queue got=%0d busy cycles want=0", busy_seen); end
      n_cmp++; if (mif.hi_o !== last_hi || mif.lo_o !== last_lo) begin
         n_err++; $display("FAIL cancel_run_hold got=%h_%h want=%h_%h", mif.hi_o, mif.lo_o, last_hi, last_lo);
      end

      // Cancel arriving in the DONE cycle.
      mif.op_i    = 2'b11;
      mif.a_i     = 32'd50;
      mif.b_i     = 32'd6;
      mif.start_i = 1'b1;
      tick();
      mif.start_i = 1'b0;
      repeat (W) tick();
      mif.cancel_i = 1'b1;
      #1;
      n_cmp++; if (mif.done_o !== 1'b0) begin n_err++; $display("FAIL cancel_done_pulse got=%b want=0", mif.done_o); end
      n_cmp++; if (mif.hi_o !== last_hi || mif.lo_o !== last_lo) begin
         n_err++; $display("FAIL cancel_done_out got=%h_%h want=%h_%h", mif.hi_o, mif.lo_o, last_hi, last_lo);
      end
      tick();
      mif.cancel_i = 1'b0;
      #1;
      n_cmp++; if (mif.busy_o !== 1'b0 || mif.hi_o !== last_hi || mif.lo_o !== last_lo) begin
         n_err++; $display("FAIL cancel_done_after busy=%b got=%h_%h want=0 %h_%h", mif.busy_o, mif.hi_o, mif.lo_o, last_hi, last_lo);
      end

      // Start and cancel together in IDLE: start dropped.
      mif.op_i     = 2'b10;
      mif.a_i      = 32'd9;
      mif.b_i      = 32'd0;
      mif.start_i  = 1'b1;
      mif.cancel_i = 1'b1;
      #1;
      n_cmp++; if (mif.stallreq_o !== 1'b0) begin n_err++; $display("FAIL idle_cancel_stall got=%b want=0", mif.stallreq_o); end
      tick();
      mif.start_i  = 1'b0;
      mif.cancel_i = 1'b0;
      #1;
      n_cmp++; if (mif.busy_o !== 1'b0 || mif.done_o !== 1'b0) begin
         n_err++; $display("FAIL idle_cancel_drop busy=%b done=%b want=0 0", mif.busy_o, mif.done_o);
      end
   endtask

   task automatic test_reset_mid_op;
      logic [1:0]   op;
      logic [W-1:0] a, b, eh, el, hi, lo, hi2, lo2;
      int lat;
      bit seen;
      mif.op_i    = 2'b10;
      mif.a_i     = 32'hFFFF0000;
      mif.b_i     = 32'd13;
      mif.start_i = 1'b1;
      tick();
      mif.start_i = 1'b0;
      repeat (4) tick();
      rst = 1'b1;
      tick();
      #1;
      n_cmp++; if (mif.busy_o !== 1'b0 || mif.done_o !== 1'b0) begin
         n_err++; $display("FAIL midrst_ctrl busy=%b done=%b want=0 0", mif.busy_o, mif.done_o);
      end
      n_cmp++; if (mif.hi_o !== '0 || mif.lo_o !== '0) begin
         n_err++; $display("FAIL midrst_out got=%h_%h want=0_0", mif.hi_o, mif.lo_o);
      end
      rst     = 1'b0;
      last_hi = '0;
      last_lo = '0;
      op = 2'b00;
      a  = $urandom;
      b  = $urandom;
      model(op, a, b, eh, el);
      run_op(op, a, b, lat, hi, lo, hi2, lo2, seen);
      n_cmp++; if (!seen || hi !== eh || lo !== el) begin
         n_err++; $display("FAIL midrst_fresh seen=%b got=%h_%h want=%h_%h", seen, hi, lo, eh, el);
      end
      last_hi = eh;
      last_lo = el;
   endtask

   task automatic test_back_to_back;
      logic [1:0]   op;
      logic [W-1:0] a, b, eh, el, hi, lo, hi2, lo2;
      int lat;
      bit seen;
      // run_op returns in the IDLE cycle after done_o; the next start goes in that same cycle.
      for (int n = 0; n < 6; n++) begin
         op = 2'(n % 4);
         a  = $urandom;
         b  = (n == 5) ? 32'd0 : $urandom;
         model(op, a, b, eh, el);
         run_op(op, a, b, lat, hi, lo, hi2, lo2, seen);
         n_cmp++; if (!seen || lat != exp_latency(op, b) || hi !== eh || lo !== el) begin
            n_err++; $display("FAIL b2b%0d seen=%b lat=%0d got=%h_%h want lat=%0d %h_%h", n, seen, lat, hi, lo, exp_latency(op, b), eh, el);
         end
         last_hi = eh;
         last_lo = el;
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_cancel();
      test_reset_mid_op();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
